accel_ctrl: RTL

ACCEL_CTRL -- requirements
Module: accel_ctrl

---
 rtl/accel_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/accel_ctrl.sv
// Accelerometer sequencer: powers the sensor up over SPI, then bursts six axis-register reads every SAMPLE_CYCLES.
// Exactly one SPI transaction outstanding at a time; a burst in flight always completes before enable is honoured.
module accel_ctrl #(
  parameter logic [23:0] STARTUP_CYCLES = 24'd2000,
  parameter logic [23:0] SAMPLE_CYCLES  = 24'd20000
) (
  input  logic        spi_clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        spi_start,
  output logic [15:0] spi_data_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_data_rx,
  output logic        init_done,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic [15:0] data_z,
  output logic        data_valid
);

  typedef enum logic [2:0] {
    STARTUP, INIT_ISSUE, INIT_WAIT, IDLE_WAIT, RD_ISSUE, RD_WAIT, UPDATE
  } state_t;

  typedef struct packed {
    logic       rd;
    logic       mb;
    logic [5:0] addr;
    logic [7:0] wdata;
  } spi_cmd_t;

  localparam logic [1:0][15:0] INIT_TABLE = {16'h2D08, 16'h3108};
  localparam logic [23:0] TIMER_LOAD = (SAMPLE_CYCLES == 24'd0) ? 24'd0 : SAMPLE_CYCLES - 24'd1;

  state_t          state, state_next;
  logic [2:0]      idx, idx_next;
  logic [23:0]     startup_cnt, startup_next;
  logic [23:0]     timer, timer_next;
  logic [15:0]     tx_next;
  logic            init_done_next;
  logic [5:0][7:0] shadow, shadow_next;
  logic            load_out;
  logic            startup_over;
  logic            burst_go;
  spi_cmd_t        rd_cmd;

  assign startup_over = ({1'b0, startup_cnt} + 25'd1) >= {1'b0, STARTUP_CYCLES};
  assign burst_go     = (timer == 24'd0) && enable;

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    startup_next   = startup_cnt;
    timer_next     = (timer != 24'd0) ? timer - 24'd1 : 24'd0;
    tx_next        = spi_data_tx;
    init_done_next = init_done;
    shadow_next    = shadow;
    load_out       = 1'b0;
    spi_start      = 1'b0;
    rd_cmd         = '0;

    case (state)
      STARTUP: begin
        if (startup_over) begin
          state_next = INIT_ISSUE;
          idx_next   = 3'd0;
        end else begin
          startup_next = startup_cnt + 24'd1;
        end
      end
      INIT_ISSUE: begin
        spi_start  = 1'b1;
        state_next = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (spi_done) begin
          if (idx == 3'd0) begin
            idx_next   = 3'd1;
            state_next = INIT_ISSUE;
          end else begin
            idx_next       = 3'd0;
            init_done_next = 1'b1;
            state_next     = IDLE_WAIT;
          end
        end
      end
      IDLE_WAIT: begin
        if (burst_go) begin
          state_next = RD_ISSUE;
          idx_next   = 3'd0;
          timer_next = TIMER_LOAD;
        end
      end
      RD_ISSUE: begin
        spi_start  = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (spi_done) begin
          shadow_next[idx] = spi_data_rx;
          if (idx == 3'd5) begin
            state_next = UPDATE;
          end else begin
            idx_next   = idx + 3'd1;
            state_next = RD_ISSUE;
          end
        end
      end
      UPDATE: begin
        load_out = 1'b1;
        idx_next = 3'd0;
        // An overrunning burst leaves the timer at 0: chain straight into the next one.
        if (burst_go) begin
          state_next = RD_ISSUE;
          timer_next = TIMER_LOAD;
        end else begin
          state_next = IDLE_WAIT;
        end
      end
      default: state_next = STARTUP;
    endcase

    rd_cmd.rd   = 1'b1;
    rd_cmd.addr = 6'h32 + {3'b000, idx_next};
    if (state_next == INIT_ISSUE) begin
      tx_next = INIT_TABLE[idx_next[0]];
    end else if (state_next == RD_ISSUE) begin
      tx_next = rd_cmd;
    end
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= STARTUP;
      idx         <= 3'd0;
      startup_cnt <= 24'd0;
      timer       <= 24'd0;
      spi_data_tx <= 16'd0;
      init_done   <= 1'b0;
      shadow      <= '0;
      data_x      <= 16'd0;
      data_y      <= 16'd0;
      data_z      <= 16'd0;
      data_valid  <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      startup_cnt <= startup_next;
      timer       <= timer_next;
      spi_data_tx <= tx_next;
      init_done   <= init_done_next;
      shadow      <= shadow_next;
      data_valid  <= load_out;
      if (load_out) begin
        data_x <= {shadow[1], shadow[0]};
        data_y <= {shadow[3], shadow[2]};
        data_z <= {shadow[5], shadow[4]};
      end
    end
  end

endmodule
